// File: rtl/lampara_pwm_ctrl.sv
// lampara_pwm_ctrl
//
// Consumer end of the alarm light-command interface. It keeps a target duty
// cycle from the accion/dutty commands, moves the applied duty toward that
// target once per PWM period, and drives the lamp with a registered,
// glitch-free PWM signal.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   accion[1:0]  command: 00 hold, 01 off, 10 target = dutty, 11 full on
//   dutty[15:0]  requested duty in counts (used only with accion = 10)
//   pwm_out      registered lamp PWM
//   duty_actual  duty applied during the current PWM period
//   estado[1:0]  ramp status (see table below)
//   periodo_fin  one-cycle pulse on the last cycle of each PWM period
//
// estado | meaning
// -------+-----------------------------------------------
// 00     | APAGADA  target and applied duty are both zero
// 01     | SUBIENDO applied duty below target, ramping up
// 10     | BAJANDO  applied duty above target, ramping down
// 11     | ESTABLE  applied duty equals a non-zero target

module lampara_pwm_ctrl #(
  parameter int PERIOD    = 50000,
  parameter int RAMP_STEP = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  accion,
  input  logic [15:0] dutty,
  output logic        pwm_out,
  output logic [15:0] duty_actual,
  output logic [1:0]  estado,
  output logic        periodo_fin
);

  // A step wider than the duty range behaves as an immediate jump.
  localparam int STEP_SAT = (RAMP_STEP > 65535) ? 65535 : RAMP_STEP;

  localparam logic [15:0] PERIOD_W = 16'(PERIOD);
  localparam logic [15:0] LAST     = 16'(PERIOD - 1);
  localparam logic [15:0] STEP_W   = 16'(STEP_SAT);

  typedef enum logic [1:0] {
    APAGADA  = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10,
    ESTABLE  = 2'b11
  } estado_t;

  logic [15:0] cnt;
  logic [15:0] target;
  logic        off_pending;
  estado_t     estado_q;

  logic        wrap;
  logic [15:0] cnt_nxt;
  logic [15:0] target_nxt;
  logic        off_nxt;
  logic [15:0] duty_nxt;
  logic [15:0] diff;
  estado_t     estado_nxt;

  assign wrap    = (cnt == LAST);
  assign cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;

  // Command decode. The boundary cycle clears off_pending, but a command in
  // that same cycle still wins so it is honoured at the following boundary.
  always_comb begin
    target_nxt = target;
    off_nxt    = wrap ? 1'b0 : off_pending;
    case (accion)
      2'b01: begin
        target_nxt = 16'd0;
        off_nxt    = 1'b1;
      end
      2'b10: begin
        target_nxt = (dutty > PERIOD_W) ? PERIOD_W : dutty;
        off_nxt    = 1'b0;
      end
      2'b11: begin
        target_nxt = PERIOD_W;
        off_nxt    = 1'b0;
      end
      default: ;
    endcase
  end

  // Duty ramp, evaluated only at the wrap and always against the target held
  // before this cycle's command. Working on the difference keeps the update
  // free of overflow/underflow at either end of the 16-bit range.
  always_comb begin
    duty_nxt = duty_actual;
    diff     = 16'd0;
    if (wrap) begin
      if (off_pending) begin
        duty_nxt = 16'd0;
      end else if (duty_actual < target) begin
        diff     = target - duty_actual;
        duty_nxt = (diff <= STEP_W) ? target : duty_actual + STEP_W;
      end else if (duty_actual > target) begin
        diff     = duty_actual - target;
        duty_nxt = (diff <= STEP_W) ? target : duty_actual - STEP_W;
      end
    end
  end

  always_comb begin
    estado_nxt = ESTABLE;
    if (target_nxt == 16'd0 && duty_nxt == 16'd0) begin
      estado_nxt = APAGADA;
    end else if (duty_nxt < target_nxt) begin
      estado_nxt = SUBIENDO;
    end else if (duty_nxt > target_nxt) begin
      estado_nxt = BAJANDO;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 16'd0;
      target      <= 16'd0;
      off_pending <= 1'b0;
      duty_actual <= 16'd0;
      pwm_out     <= 1'b0;
      periodo_fin <= 1'b0;
      estado_q    <= APAGADA;
    end else begin
      cnt         <= cnt_nxt;
      // Registered against the next count so the pulse coincides with the
      // cycle in which cnt holds its last value.
      periodo_fin <= (cnt_nxt == LAST);
      pwm_out     <= (cnt < duty_actual);
      target      <= target_nxt;
      off_pending <= off_nxt;
      duty_actual <= duty_nxt;
      estado_q    <= estado_nxt;
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_lampara_pwm_ctrl.sv
module tb_lampara_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  accion = 2'b00;
  logic [15:0] dutty = 16'd0;
  logic        pwm_out;
  logic [15:0] duty_actual;
  logic [1:0]  estado;
  logic        periodo_fin;

  localparam logic [1:0] APAG = 2'b00, SUB = 2'b01, BAJ = 2'b10, EST = 2'b11;

  lampara_pwm_ctrl #(.PERIOD(10), .RAMP_STEP(3)) dut (
    .clk(clk), .rst(rst), .accion(accion), .dutty(dutty),
    .pwm_out(pwm_out), .duty_actual(duty_actual), .estado(estado),
    .periodo_fin(periodo_fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [15:0] duty;
    logic [1:0]  est;
    int         high;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pid = 0;

  task automatic chk(input string name, input int id, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s (period %0d) got %0d want %0d", name, id, got, want);
    end
  endtask

  // Monitor: captures duty/estado on each periodo_fin, then in the following
  // cycle (which still shows the last PWM bit of that period) compares the
  // captured values and the PWM high count against the oldest expectation.
  initial begin : monitor
    int          hcnt;
    bit          pend;
    logic [15:0] cap_d;
    logic [1:0]  cap_e;
    exp_t        e;
    hcnt = 0;
    pend = 0;
    cap_d = '0;
    cap_e = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hcnt = 0;
        pend = 0;
      end else begin
        hcnt += int'(pwm_out);
        if (pend) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("duty_actual", e.id, int'(cap_d), int'(e.duty));
            chk("estado", e.id, int'(cap_e), int'(e.est));
            chk("pwm_high_cycles", e.id, hcnt, e.high);
          end
          hcnt = 0;
          pend = 0;
        end
        if (periodo_fin) begin
          pend  = 1;
          cap_d = duty_actual;
          cap_e = estado;
        end
      end
    end
  end

  // Runs one PWM period, starting from the negedge of the previous period's
  // last cycle. Commands are held for the whole cycle in which cnt == c1/c2
  // (-1 means none). Ends on the negedge of this period's last cycle.
  task automatic period(input logic [1:0] a1, input logic [15:0] d1, input int c1,
                        input logic [1:0] a2, input logic [15:0] d2, input int c2,
                        input logic [15:0] ed, input logic [1:0] ee, input int eh);
    bit early;
    exp_t e;
    early = 0;
    pid++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 9 && periodo_fin) early = 1;
      if (c == c1) begin
        accion = a1; dutty = d1;
      end else if (c == c2) begin
        accion = a2; dutty = d2;
      end else begin
        accion = 2'b00; dutty = 16'd0;
      end
    end
    chk("periodo_fin_position", pid, int'(periodo_fin && !early), 1);
    e.id = pid; e.duty = ed; e.est = ee; e.high = eh;
    sb.push_back(e);
  endtask

  task automatic p1(input logic [1:0] a, input logic [15:0] d, input int c,
                    input logic [15:0] ed, input logic [1:0] ee, input int eh);
    period(a, d, c, 2'b00, 16'd0, -1, ed, ee, eh);
  endtask

  task automatic p0(input logic [15:0] ed, input logic [1:0] ee, input int eh);
    period(2'b00, 16'd0, -1, 2'b00, 16'd0, -1, ed, ee, eh);
  endtask

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!periodo_fin && n < 50);
  endtask

  initial begin : driver
    int n;
    // Reset state
    @(negedge clk);
    chk("reset_pwm_out", 0, int'(pwm_out), 0);
    chk("reset_duty", 0, int'(duty_actual), 0);
    chk("reset_estado", 0, int'(estado), int'(APAG));
    chk("reset_periodo_fin", 0, int'(periodo_fin), 0);
    rst = 1'b0;
    wait_sync(n);
    chk("first_period_len", 0, n, 9);

    // Ramp up to 8
    p1(2'b10, 16'd8, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    p0(16'd6, SUB, 6);
    p0(16'd8, EST, 8);
    // Ramp down to 1
    p1(2'b10, 16'd1, 0, 16'd8, BAJ, 8);
    p0(16'd5, BAJ, 5);
    p0(16'd2, BAJ, 2);
    p0(16'd1, EST, 1);
    // Off, then clamp of dutty=40 to full on
    p1(2'b01, 16'd0, 0, 16'd1, BAJ, 1);
    p0(16'd0, APAG, 0);
    p1(2'b10, 16'd40, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    p0(16'd6, SUB, 6);
    p0(16'd9, SUB, 9);
    p0(16'd10, EST, 10);
    // Off, then full on via accion=11
    p1(2'b01, 16'd0, 0, 16'd10, BAJ, 10);
    p1(2'b11, 16'd0, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    p0(16'd6, SUB, 6);
    p0(16'd9, SUB, 9);
    p0(16'd10, EST, 10);
    // Off during ramp at duty 6
    p1(2'b01, 16'd0, 0, 16'd10, BAJ, 10);
    p1(2'b10, 16'd10, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    p1(2'b01, 16'd0, 4, 16'd6, BAJ, 6);
    p0(16'd0, APAG, 0);
    // Off cancelled by a later set in the same period
    p1(2'b10, 16'd4, 0, 16'd0, SUB, 0);
    period(2'b01, 16'd0, 2, 2'b10, 16'd4, 5, 16'd3, SUB, 3);
    p0(16'd4, EST, 4);
    // Mid-period change from duty 8
    p1(2'b10, 16'd8, 0, 16'd4, SUB, 4);
    p0(16'd7, SUB, 7);
    p0(16'd8, EST, 8);
    p1(2'b10, 16'd2, 1, 16'd8, BAJ, 8);
    p0(16'd5, BAJ, 5);
    p0(16'd2, EST, 2);
    // Command in the boundary cycle takes effect one boundary later
    p1(2'b10, 16'd9, 9, 16'd2, EST, 2);
    p0(16'd2, SUB, 2);
    p0(16'd5, SUB, 5);
    p0(16'd8, SUB, 8);
    p0(16'd9, EST, 9);
    p1(2'b01, 16'd0, 9, 16'd9, EST, 9);
    p0(16'd9, BAJ, 9);
    p0(16'd0, APAG, 0);
    // Ramp with accion=11, then asynchronous reset while pwm_out is high
    p1(2'b11, 16'd0, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    @(negedge clk);
    @(negedge clk);
    accion = 2'b10; dutty = 16'd5;
    @(negedge clk);
    accion = 2'b00; dutty = 16'd0;
    chk("pwm_high_before_reset", 46, int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm_out", 46, int'(pwm_out), 0);
    chk("async_rst_duty", 46, int'(duty_actual), 0);
    chk("async_rst_estado", 46, int'(estado), int'(APAG));
    chk("async_rst_periodo_fin", 46, int'(periodo_fin), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_sync(n);
    chk("period_len_after_rst", 46, n, 9);
    pid = 46;
    p0(16'd0, APAG, 0);
    p1(2'b10, 16'd5, 0, 16'd0, SUB, 0);
    p0(16'd3, SUB, 3);
    accion = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", pid, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lampara_pwm_ctrl.md
Name: lampara_pwm_ctrl

Overview:
- Consumer end of the alarm's light-command interface (accion/dutty).
- Accepts light commands, keeps a target duty cycle and ramps the applied duty toward it once per PWM period.
- Drives the lamp as a glitch-free PWM signal.
- Sits between the alarm state machine and the lamp driver pin; also reports ramp status.

Parameters:
PERIOD, 50000, PWM period in clk cycles (1 kHz at 50 MHz); legal range 2..65535.
RAMP_STEP, 500, maximum change of the applied duty per PWM period, in counts; must be ≥1.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
accion  input  2  command: 00 hold, 01 off, 10 set target = dutty, 11 full on
dutty  input  16  requested duty in counts; used only when accion=10
pwm_out  output  1  lamp PWM, registered
duty_actual  output  16  duty applied in the current PWM period
estado  output  2  00 APAGADA, 01 SUBIENDO, 10 BAJANDO, 11 ESTABLE
periodo_fin  output  1  one-cycle pulse on the last cycle of each PWM period

Behaviour:
- Reset (async, rst=1): cnt=0, target=0, duty_actual=0, pwm_out=0, periodo_fin=0, estado=APAGADA. Held while rst=1; on release, counting starts at the first posedge clk.
- Period counter cnt, 16 bits:
  - Counts 0..PERIOD-1, then wraps to 0.
  - periodo_fin is registered and is 1 in the cycle in which cnt==PERIOD-1.
- PWM output: pwm_out <= (cnt < duty_actual), registered, so it lags cnt by one cycle.
  - duty_actual=0 gives constant low.
  - duty_actual=PERIOD gives constant high.
- Command sampling: commands are sampled every clk and treated as levels. Repeating the same command is idempotent.
  - 00: no change.
  - 01: target=0 and the off_pending flag is set.
  - 10: target=min(dutty, PERIOD); the clamp is an unsigned compare.
  - 11: target=PERIOD.
- Simultaneous events: a command in the boundary cycle (cnt==PERIOD-1) updates target in that same cycle. The duty update in that cycle uses the old target, so the new command takes effect at the next boundary.
- Duty update: duty_actual changes only on the clock edge where cnt wraps PERIOD-1→0. A new command never alters an in-progress period.
  - If off_pending=1: duty_actual=0 (no ramp), and off_pending is cleared.
  - Else if duty_actual<target: duty_actual = (target-duty_actual ≤ RAMP_STEP) ? target : duty_actual+RAMP_STEP.
  - Else if duty_actual>target: duty_actual = (duty_actual-target ≤ RAMP_STEP) ? target : duty_actual-RAMP_STEP.
  - Arithmetic uses differences only, so there is no overflow or underflow at 0 or 65535.
- off_pending clearing: a subsequent 10 or 11 command before the boundary clears off_pending (the last command wins).
- estado, registered and updated every cycle from the next-state values:
  - APAGADA if target==0 and duty_actual==0.
  - SUBIENDO if duty_actual<target.
  - BAJANDO if duty_actual>target.
  - ESTABLE if duty_actual==target≠0.
- Reset mid-period: everything returns to its reset values immediately, and any pending command is lost.

Test Plan:
Simulation parameters for all scenarios: PERIOD=10, RAMP_STEP=3.
1. Assert rst mid-stream while pwm_out=1 -> pwm_out, duty_actual, periodo_fin and estado read 0 immediately, without waiting for a clk edge; after release, periodo_fin pulses every 10 cycles.
2. Ramp up. From APAGADA, accion=10 with dutty=8, then accion=00.
   - duty_actual steps 3→6→8 at successive wraps.
   - pwm_out is high for 3, 6, then 8 cycles per period.
   - estado reads SUBIENDO until duty_actual=8, then ESTABLE.
3. Clamp to full on. accion=10 with dutty=40 -> target clamps to 10 and duty_actual ramps 3,6,9,10; at duty 10, pwm_out is constantly high; accion=11 gives the same result.
4. Ramp down. From duty 8, accion=10 with dutty=1 -> duty_actual steps 5→2→1 and estado reads BAJANDO then ESTABLE.
5. Off during ramp. At duty 6 while ramping to 10, accion=01 -> duty_actual=0 at the next wrap and estado=APAGADA; accion=01 followed by accion=10 with dutty=4 in the same period -> no forced off, and the ramp toward 4 continues.
6. Mid-period change. Set dutty=2 at cnt=1 while duty_actual=8 -> the current period stays high for 8 cycles; the next period is high for 5 cycles.
